// File: rtl/md_issue.sv
// Issue gate in front of the multiply/divide unit: shadows the unit's busy time,
// suppresses writes while it is busy, raises the D-stage stall and keeps sticky status.
`ifndef MD_MULT
`define MD_MULT  3'b000
`endif
`ifndef MD_MULTU
`define MD_MULTU 3'b001
`endif
`ifndef MD_DIV
`define MD_DIV   3'b010
`endif
`ifndef MD_DIVU
`define MD_DIVU  3'b011
`endif

module md_issue #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        e_start,
    input  logic        e_mthi,
    input  logic        e_mtlo,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_A,
    input  logic [31:0] e_B,
    input  logic        d_md_use,
    input  logic        md_busy,
    output logic        md_start,
    output logic        md_mthi,
    output logic        md_mtlo,
    output logic [2:0]  md_op,
    output logic [31:0] md_A,
    output logic [31:0] md_B,
    output logic        stall_md,
    output logic        proto_err,
    output logic        sync_err,
    output logic        dz_flag,
    output logic [31:0] stall_cnt
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             sync_err_q, sync_err_d;
    logic             dz_flag_q, dz_flag_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic shadow_busy;
    logic op_valid;
    logic op_div;
    logic issue;
    logic any_strobe;
    logic multi_strobe;

    always_comb begin
        shadow_busy  = (cnt_q != '0);
        op_valid     = (e_op == `MD_MULT) || (e_op == `MD_MULTU) || (e_op == `MD_DIV) || (e_op == `MD_DIVU);
        op_div       = (e_op == `MD_DIV) || (e_op == `MD_DIVU);
        any_strobe   = e_start | e_mthi | e_mtlo;
        multi_strobe = (e_start & e_mthi) | (e_start & e_mtlo) | (e_mthi & e_mtlo);

        // Strobe precedence mthi > mtlo > start mirrors the unit's own decode.
        md_mthi  = e_mthi & ~req & ~shadow_busy & ~reset;
        md_mtlo  = e_mtlo & ~e_mthi & ~req & ~shadow_busy & ~reset;
        issue    = e_start & ~e_mthi & ~e_mtlo & ~req & ~shadow_busy & op_valid & ~reset;
        md_start = issue;
        md_op    = e_op;
        md_A     = e_A;
        md_B     = e_B;

        // Stalling on issue too keeps a D-stage mfhi/mflo from reading stale HI/LO.
        stall_md = d_md_use & (shadow_busy | issue) & ~reset;

        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = op_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (shadow_busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        proto_err_d = proto_err_q
                    | (~req & ((any_strobe & shadow_busy) | (e_start & ~op_valid) | multi_strobe));
        sync_err_d  = sync_err_q | (md_busy != shadow_busy);
        dz_flag_d   = dz_flag_q | (issue & op_div & (e_B == 32'd0));
        stall_cnt_d = stall_cnt_q + {31'd0, stall_md};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            proto_err_q <= 1'b0;
            sync_err_q  <= 1'b0;
            dz_flag_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            cnt_q       <= cnt_d;
            proto_err_q <= proto_err_d;
            sync_err_q  <= sync_err_d;
            dz_flag_q   <= dz_flag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign proto_err = proto_err_q;
    assign sync_err  = sync_err_q;
    assign dz_flag   = dz_flag_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_md_issue.sv
// Directed bench for md_issue: combinational vector table plus clocked corner-case sequences.
module tb_md_issue;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;

    logic        clk = 1'b0;
    logic        reset, req, e_start, e_mthi, e_mtlo, d_md_use, md_busy;
    logic [2:0]  e_op;
    logic [31:0] e_A, e_B;
    logic        md_start, md_mthi, md_mtlo, stall_md, proto_err, sync_err, dz_flag;
    logic [2:0]  md_op;
    logic [31:0] md_A, md_B, stall_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    md_issue #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .req(req),
        .e_start(e_start), .e_mthi(e_mthi), .e_mtlo(e_mtlo), .e_op(e_op),
        .e_A(e_A), .e_B(e_B), .d_md_use(d_md_use), .md_busy(md_busy),
        .md_start(md_start), .md_mthi(md_mthi), .md_mtlo(md_mtlo), .md_op(md_op),
        .md_A(md_A), .md_B(md_B), .stall_md(stall_md),
        .proto_err(proto_err), .sync_err(sync_err), .dz_flag(dz_flag), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst;
        logic       rq;
        logic       st;
        logic       hi;
        logic       lo;
        logic [2:0] op;
        logic       use_d;
        logic       x_start;
        logic       x_hi;
        logic       x_lo;
        logic       x_stall;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic idle_in();
        req = 0; e_start = 0; e_mthi = 0; e_mtlo = 0; e_op = OP_MULT;
        e_A = 0; e_B = 0; d_md_use = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        if (exp_cnt > 0) exp_cnt--;
        md_busy = (exp_cnt != 0);
    endtask

    task automatic step_issue(input int lat);
        @(posedge clk); #1;
        exp_cnt = lat;
        md_busy = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1; idle_in(); md_busy = 0; exp_cnt = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    task automatic run_out();
        for (int k = 0; k < 12 && exp_cnt != 0; k++) step();
    endtask

    vec_t vt [11];

    initial begin
        vt[0]  = '{0,0,1,0,0,OP_MULT, 0, 1,0,0,0};
        vt[1]  = '{0,0,1,0,0,OP_MULTU,1, 1,0,0,1};
        vt[2]  = '{0,0,1,0,0,3'b101,  1, 0,0,0,0};
        vt[3]  = '{0,1,1,0,0,OP_DIVU, 1, 0,0,0,0};
        vt[4]  = '{0,0,0,1,0,OP_MULT, 0, 0,1,0,0};
        vt[5]  = '{0,0,0,0,1,OP_MULT, 0, 0,0,1,0};
        vt[6]  = '{0,0,0,1,1,OP_MULT, 0, 0,1,0,0};
        vt[7]  = '{0,0,1,0,1,OP_DIV,  1, 0,0,1,0};
        vt[8]  = '{0,1,0,1,0,OP_MULT, 0, 0,0,0,0};
        vt[9]  = '{0,0,0,0,0,OP_MULT, 1, 0,0,0,0};
        vt[10] = '{1,0,1,1,0,OP_MULT, 1, 0,0,0,0};

        reset = 1; idle_in(); md_busy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_proto", proto_err, 0);
        chk("reset_stallcnt", stall_cnt, 0);
        chk("reset_cnt", dut.cnt_q, 0);
        reset = 0;

        // Combinational vectors, inputs idled again before each edge.
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            reset = vt[i].rst; req = vt[i].rq; e_start = vt[i].st;
            e_mthi = vt[i].hi; e_mtlo = vt[i].lo; e_op = vt[i].op; d_md_use = vt[i].use_d;
            e_A = 32'h1000 + i; e_B = 32'hA5A5_0000 ^ i;
            #1;
            chk($sformatf("v%0d_start", i), md_start, vt[i].x_start);
            chk($sformatf("v%0d_mthi", i), md_mthi, vt[i].x_hi);
            chk($sformatf("v%0d_mtlo", i), md_mtlo, vt[i].x_lo);
            chk($sformatf("v%0d_stall", i), stall_md, vt[i].x_stall);
            chk($sformatf("v%0d_op", i), md_op, vt[i].op);
            chk($sformatf("v%0d_A", i), md_A, 32'h1000 + i);
            chk($sformatf("v%0d_B", i), md_B, 32'hA5A5_0000 ^ i);
            #1;
            reset = 0; idle_in();
        end
        @(posedge clk); #1;
        chk("tbl_proto", proto_err, 0);
        chk("tbl_cnt", dut.cnt_q, 0);

        // mult with D-stage user: six stall cycles
        do_reset();
        e_start = 1; e_op = OP_MULT; e_B = 0; d_md_use = 1;
        #1;
        chk("A_issue_start", md_start, 1);
        chk("A_issue_stall", stall_md, 1);
        step_issue(5);
        e_start = 0;
        #1;
        chk("A_cnt5", dut.cnt_q, 5);
        chk("A_stall_busy", stall_md, 1);
        chk("A_dz_mult", dz_flag, 0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("A_cnt_t%0d", k), dut.cnt_q, 5 - k);
            chk($sformatf("A_stall_t%0d", k), stall_md, (k < 5) ? 1 : 0);
        end
        chk("A_stallcnt", stall_cnt, 6);
        chk("A_sync", sync_err, 0);
        chk("A_proto", proto_err, 0);

        // divu by zero without a D-stage user
        do_reset();
        e_start = 1; e_op = OP_DIVU; e_B = 0; d_md_use = 0;
        #1;
        chk("B_start", md_start, 1);
        chk("B_stall0", stall_md, 0);
        step_issue(10);
        e_start = 0;
        #1;
        chk("B_dz", dz_flag, 1);
        chk("B_cnt10", dut.cnt_q, 10);
        chk("B_stall", stall_md, 0);
        run_out();
        chk("B_stallcnt", stall_cnt, 0);
        chk("B_dz_sticky", dz_flag, 1);
        chk("B_proto", proto_err, 0);

        // flushed start
        do_reset();
        e_start = 1; e_op = OP_MULT; req = 1; d_md_use = 1;
        #1;
        chk("C_start", md_start, 0);
        chk("C_stall", stall_md, 0);
        step();
        chk("C_cnt", dut.cnt_q, 0);
        chk("C_proto", proto_err, 0);
        chk("C_stallcnt", stall_cnt, 0);

        // flush while busy: countdown continues
        do_reset();
        e_start = 1; e_op = OP_MULTU;
        step_issue(5);
        req = 1;
        step();
        chk("R_cnt4", dut.cnt_q, 4);
        chk("R_proto", proto_err, 0);
        idle_in();
        run_out();

        // mthi while busy with cnt = 3
        do_reset();
        e_start = 1; e_op = OP_MULT;
        step_issue(5);
        e_start = 0;
        step(); step();
        chk("D_cnt3", dut.cnt_q, 3);
        e_mthi = 1;
        #1;
        chk("D_mthi", md_mthi, 0);
        step();
        e_mthi = 0;
        chk("D_proto", proto_err, 1);
        chk("D_cnt2", dut.cnt_q, 2);
        run_out();
        chk("D_proto_sticky", proto_err, 1);

        // reset mid-divide at cnt = 7
        do_reset();
        e_start = 1; e_op = OP_DIV; e_B = 7; d_md_use = 1;
        step_issue(10);
        e_start = 0;
        step(); step(); step();
        chk("E_cnt7", dut.cnt_q, 7);
        chk("E_stallcnt4", stall_cnt, 4);
        chk("E_dz", dz_flag, 0);
        reset = 1; e_start = 1; e_op = OP_MULT; e_mthi = 1;
        #1;
        chk("E_rst_stall", stall_md, 0);
        chk("E_rst_start", md_start, 0);
        chk("E_rst_mthi", md_mthi, 0);
        @(posedge clk); #1;
        reset = 0; idle_in(); md_busy = 0; exp_cnt = 0;
        chk("E_cnt0", dut.cnt_q, 0);
        chk("E_stallcnt0", stall_cnt, 0);

        // unit busy drops out early at cnt = 4
        do_reset();
        e_start = 1; e_op = OP_MULT;
        step_issue(5);
        e_start = 0;
        step();
        chk("F_cnt4", dut.cnt_q, 4);
        chk("F_sync0", sync_err, 0);
        md_busy = 0;
        step();
        chk("F_sync1", sync_err, 1);
        run_out();
        step();
        chk("F_sync_sticky", sync_err, 1);

        // invalid opcode
        do_reset();
        e_start = 1; e_op = 3'b110; d_md_use = 1;
        #1;
        chk("G_start", md_start, 0);
        step();
        idle_in();
        chk("G_proto", proto_err, 1);
        chk("G_cnt", dut.cnt_q, 0);

        // start together with mthi: mthi wins, error flagged
        do_reset();
        e_start = 1; e_mthi = 1; e_op = OP_MULT;
        #1;
        chk("H_mthi", md_mthi, 1);
        chk("H_start", md_start, 0);
        step();
        idle_in();
        chk("H_proto", proto_err, 1);
        chk("H_cnt", dut.cnt_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_issue.md
MD_ISSUE -- requirements
Module: md_issue

Interface
REQ-001 SHALL provide parameter MUL_LAT, default 5, cycles the multiply/divide unit holds busy after a mult/multu start.
REQ-002 SHALL provide parameter DIV_LAT, default 10, cycles the multiply/divide unit holds busy after a div/divu start.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  1  exception/interrupt flush of the E-stage instruction this cycle.
REQ-006 SHALL have ports e_start, e_mthi, e_mtlo  input  1 each  E-stage instruction is mult-class / mthi / mtlo.
REQ-007 SHALL have port e_op  input  3  operation code using the project `mult, `multu, `div, `divu encodings.
REQ-008 SHALL have ports e_A, e_B  input  32 each  E-stage forwarded operands.
REQ-009 SHALL have port d_md_use  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
REQ-010 SHALL have port md_busy  input  1  busy from the multiply/divide unit.
REQ-011 SHALL have ports md_start, md_mthi, md_mtlo  output  1 each; md_op  output  3; md_A, md_B  output  32 each  drive the multiply/divide unit.
REQ-012 SHALL have port stall_md  output  1  D-stage stall request to the hazard unit.
REQ-013 SHALL have ports proto_err, sync_err, dz_flag  output  1 each  sticky status flags.
REQ-014 SHALL have port stall_cnt  output  32  count of cycles with stall_md high.

Function
REQ-015 SHALL keep a down-counter cnt sized to hold max(MUL_LAT, DIV_LAT); shadow_busy = (cnt != 0).
REQ-016 SHALL define issue = e_start & ~req & (cnt == 0) & (e_op is one of the four valid encodings).
REQ-017 SHALL drive md_start = issue, md_mthi = e_mthi & ~req & (cnt == 0), md_mtlo = e_mtlo & ~req & (cnt == 0), combinationally, same cycle.
REQ-018 SHALL pass e_op, e_A, e_B to md_op, md_A, md_B unchanged and combinationally.
REQ-019 SHALL, at the edge where issue is high, load cnt with MUL_LAT for mult/multu or DIV_LAT for div/divu; otherwise decrement cnt when nonzero; otherwise hold cnt at 0.
REQ-020 SHALL drive stall_md = d_md_use & (shadow_busy | issue), combinationally; mfhi/mflo in D therefore never read stale HI/LO.
REQ-021 SHALL set proto_err at the next edge if e_start, e_mthi or e_mtlo is high, req is low, and cnt != 0 (the instruction is suppressed).
REQ-022 SHALL set proto_err if e_start is high, req is low, and e_op is not a valid encoding; md_start stays 0 and cnt is unchanged.
REQ-023 SHALL set proto_err if more than one of e_start, e_mthi, e_mtlo is high with req low; precedence for the output strobes is mthi > mtlo > start, matching the unit.
REQ-024 SHALL set sync_err at any edge where md_busy != shadow_busy, sampled before cnt updates.
REQ-025 SHALL set dz_flag at the edge where issue is high for div/divu with e_B == 0; the operation still issues.
REQ-026 SHALL increment stall_cnt by 1 at each edge where stall_md is high, wrapping from 0xFFFFFFFF to 0.
REQ-027 SHALL keep proto_err, sync_err and dz_flag high once set, until reset.
REQ-028 SHALL, with req high, neither issue nor load cnt; an in-flight operation (cnt != 0) SHALL continue its countdown.

Reset
REQ-029 SHALL, with reset high at an edge, clear cnt, proto_err, sync_err, dz_flag and stall_cnt to 0, including mid-operation.
REQ-030 SHALL, while reset is high, force md_start, md_mthi, md_mtlo and stall_md to 0 regardless of other inputs.

Verification
REQ-031 SHALL be tested with mult issued at edge t and d_md_use held high -> stall_md high for the issue cycle plus 5 cycles; stall_cnt = 6; cnt = 0 at edge t+5.
REQ-032 SHALL be tested with divu issued with e_B = 0 -> dz_flag = 1, cnt loaded with 10, stall_md low when d_md_use is low.
REQ-033 SHALL be tested with e_start high and req high -> md_start = 0, cnt stays 0, proto_err stays 0.
REQ-034 SHALL be tested with e_mthi high while cnt = 3 -> md_mthi = 0 and proto_err = 1 at the next edge.
REQ-035 SHALL be tested with reset asserted while cnt = 7 -> cnt = 0 and stall_cnt = 0 at the next edge; stall_md = 0 during reset.
REQ-036 SHALL be tested with md_busy forced low while cnt = 4 -> sync_err = 1 at the next edge and it remains 1.
